// File: rtl/ddr_line_fetch.sv
// ddr_line_fetch: scanline prefetcher feeding a pixel FIFO from DDR burst-of-2 reads.
// Ports:
//   clk133_p_i      sole clock, rising edge
//   rst_i           asynchronous reset, active low
//   frame_start_i   pulse: line counter/address back to FRAME_BASE, clears underflow
//   line_start_i    pulse: (re)start fetching the current scanline
//   rd_req_o        burst read request, rd_addr_o its even start address
//   rd_ack_i        request accepted; rd_valid_i/rd_data_i return one word per pulse
//   pix_rd_i        pop FIFO head; pix_data_o head (0 when empty), pix_empty_o
//   line_done_o     pulse after the last word of a line is written
//   underflow_o     sticky, pop attempted while empty
// Build option: FETCH_LINE_DOUBLE_EN fetches every source line twice (2x vertical scan).
module ddr_line_fetch #(
    parameter int ADDR_W     = 25,
    parameter int LINE_WORDS = 640,
    parameter int LINES      = 480,
    parameter int FIFO_DEPTH = 32,
    parameter int FRAME_BASE = 0
) (
    input  logic              clk133_p_i,
    input  logic              rst_i,
    input  logic              frame_start_i,
    input  logic              line_start_i,
    output logic              rd_req_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic              rd_ack_i,
    input  logic              rd_valid_i,
    input  logic [15:0]       rd_data_i,
    input  logic              pix_rd_i,
    output logic [15:0]       pix_data_o,
    output logic              pix_empty_o,
    output logic              line_done_o,
    output logic              underflow_o
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int WW = $clog2(LINE_WORDS + 1);
    localparam int LW = LINES > 1 ? $clog2(LINES) : 1;
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(FRAME_BASE);
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(LINE_WORDS);

    typedef enum logic [2:0] {IDLE, REQ, WAIT0, WAIT1, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [WW-1:0]     words_left_q, words_left_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d, line_addr_q, line_addr_d, rd_addr_q, rd_addr_d;
    logic [LW-1:0]     line_cnt_q, line_cnt_d;
    logic [1:0]        drain_q, drain_d, rem;
    logic              restart_q, restart_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [15:0]       mem_q [FIFO_DEPTH];
    logic [15:0]       pix_data_q, pix_data_d;
    logic              rd_req_q, rd_req_d, pix_empty_q, pix_empty_d;
    logic              line_done_q, line_done_d, underflow_q, underflow_d;
    logic              wr_en, pop, flush, go, suppress, adv, last;
`ifdef FETCH_LINE_DOUBLE_EN
    logic              dbl_q, dbl_d;
`endif

    always_comb begin
        state_d      = state_q;
        words_left_d = words_left_q;
        cur_addr_d   = cur_addr_q;
        line_addr_d  = line_addr_q;
        line_cnt_d   = line_cnt_q;
        drain_d      = drain_q;
        restart_d    = restart_q;
`ifdef FETCH_LINE_DOUBLE_EN
        dbl_d        = dbl_q;
`endif
        wr_en        = 1'b0;
        flush        = 1'b0;
        go           = 1'b0;
        suppress     = 1'b0;
        adv          = 1'b0;
        line_done_d  = 1'b0;
        // words of the outstanding burst still to arrive after this cycle
        rem          = (state_q == WAIT0 ? 2'd2 : 2'd1) - {1'b0, rd_valid_i};
        underflow_d  = (underflow_q && !frame_start_i) || (pix_rd_i && count_q == '0);
        last         = line_cnt_q == LW'(LINES - 1);
        if (frame_start_i) begin
            line_cnt_d  = '0;
            line_addr_d = BASE;
`ifdef FETCH_LINE_DOUBLE_EN
            dbl_d       = 1'b0;
`endif
        end
        case (state_q)
            IDLE: go = line_start_i;
            REQ: begin
                if (rd_req_q && rd_ack_i) begin
                    if (line_start_i || frame_start_i) begin
                        state_d   = DRAIN;
                        drain_d   = 2'd2;
                        restart_d = line_start_i;
                        flush     = 1'b1;
                    end else begin
                        state_d = WAIT0;
                    end
                end else if (line_start_i) begin
                    // one idle cycle so rd_addr never moves under an asserted request
                    go       = 1'b1;
                    suppress = 1'b1;
                end else if (frame_start_i) begin
                    state_d = IDLE;
                end
            end
            WAIT0, WAIT1: begin
                if (line_start_i || frame_start_i) begin
                    flush     = 1'b1;
                    drain_d   = rem;
                    restart_d = line_start_i;
                    state_d   = rem == 2'd0 ? IDLE : DRAIN;
                    go        = rem == 2'd0 && line_start_i;
                end else if (rd_valid_i) begin
                    wr_en = 1'b1;
                    if (state_q == WAIT0) begin
                        state_d = WAIT1;
                    end else begin
                        cur_addr_d   = cur_addr_q + ADDR_W'(2);
                        words_left_d = words_left_q - WW'(2);
                        adv          = words_left_q == WW'(2);
                        line_done_d  = adv;
                        state_d      = adv ? IDLE : REQ;
                    end
                end
            end
            DRAIN: begin
                flush     = 1'b1;
                restart_d = line_start_i || (restart_q && !frame_start_i);
                if (rd_valid_i) drain_d = drain_q - 2'd1;
                if (rd_valid_i && drain_q == 2'd1) begin
                    state_d = IDLE;
                    go      = restart_d;
                end
            end
            default: state_d = IDLE;
        endcase
        if (adv) begin
            line_cnt_d  = last ? '0 : line_cnt_q + LW'(1);
`ifdef FETCH_LINE_DOUBLE_EN
            dbl_d       = !last && !dbl_q;
            line_addr_d = last ? BASE : dbl_q ? line_addr_q + STEP : line_addr_q;
`else
            line_addr_d = last ? BASE : line_addr_q + STEP;
`endif
        end
        if (go) begin
            state_d      = REQ;
            words_left_d = WW'(LINE_WORDS);
            cur_addr_d   = line_addr_d;
            flush        = 1'b1;
        end
    end

    always_comb begin
        pop         = pix_rd_i && count_q != '0 && !flush;
        wr_ptr_d    = flush ? '0 : wr_ptr_q + PW'(wr_en);
        rd_ptr_d    = flush ? '0 : rd_ptr_q + PW'(pop);
        count_d     = flush ? '0 : count_q + CW'(wr_en) - CW'(pop);
        // only request when two free entries guarantee the burst fits
        rd_req_d    = state_d == REQ && !suppress && count_d <= CW'(FIFO_DEPTH - 2);
        rd_addr_d   = state_d == REQ ? cur_addr_d : rd_addr_q;
        pix_empty_d = count_d == '0;
        // bypass the word being written when it becomes the new head
        pix_data_d  = pix_empty_d ? '0 : (wr_en && rd_ptr_d == wr_ptr_q) ? rd_data_i : mem_q[rd_ptr_d];
    end

    always_ff @(posedge clk133_p_i) begin
        if (wr_en) mem_q[wr_ptr_q] <= rd_data_i;
    end

    always_ff @(posedge clk133_p_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= IDLE;
            words_left_q <= '0;
            cur_addr_q   <= BASE;
            line_addr_q  <= BASE;
            line_cnt_q   <= '0;
            drain_q      <= '0;
            restart_q    <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            rd_req_q     <= 1'b0;
            rd_addr_q    <= '0;
            pix_data_q   <= '0;
            pix_empty_q  <= 1'b1;
            line_done_q  <= 1'b0;
            underflow_q  <= 1'b0;
`ifdef FETCH_LINE_DOUBLE_EN
            dbl_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            words_left_q <= words_left_d;
            cur_addr_q   <= cur_addr_d;
            line_addr_q  <= line_addr_d;
            line_cnt_q   <= line_cnt_d;
            drain_q      <= drain_d;
            restart_q    <= restart_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            rd_req_q     <= rd_req_d;
            rd_addr_q    <= rd_addr_d;
            pix_data_q   <= pix_data_d;
            pix_empty_q  <= pix_empty_d;
            line_done_q  <= line_done_d;
            underflow_q  <= underflow_d;
`ifdef FETCH_LINE_DOUBLE_EN
            dbl_q        <= dbl_d;
`endif
        end
    end

    assign rd_req_o    = rd_req_q;
    assign rd_addr_o   = rd_addr_q;
    assign pix_data_o  = pix_data_q;
    assign pix_empty_o = pix_empty_q;
    assign line_done_o = line_done_q;
    assign underflow_o = underflow_q;
endmodule

// File: tb/tb_ddr_line_fetch.sv
// tb_ddr_line_fetch: directed bench for ddr_line_fetch (8-word lines, 3 lines, 4-entry FIFO, base 0x40).
module tb_ddr_line_fetch;
    localparam logic [24:0] BASE = 25'h40;

    logic        clk = 1'b0, rst_n = 1'b0, frame_start = 1'b0, line_start = 1'b0;
    logic        rd_ack = 1'b0, rd_valid = 1'b0, pix_rd = 1'b0;
    logic [15:0] rd_data = '0;
    logic        rd_req, pix_empty, line_done, underflow;
    logic [24:0] rd_addr;
    logic [15:0] pix_data;

    int          n_checks = 0, n_fail = 0, npop = 0, nreq = 0, nld = 0;
    logic [15:0] popped [64];
    logic [24:0] addrs [32];
    bit          pop_en = 1'b0;

    always #5 clk = ~clk;

    ddr_line_fetch #(.ADDR_W(25), .LINE_WORDS(8), .LINES(3), .FIFO_DEPTH(4), .FRAME_BASE(32'h40)) dut (
        .clk133_p_i(clk), .rst_i(rst_n), .frame_start_i(frame_start), .line_start_i(line_start),
        .rd_req_o(rd_req), .rd_addr_o(rd_addr), .rd_ack_i(rd_ack), .rd_valid_i(rd_valid),
        .rd_data_i(rd_data), .pix_rd_i(pix_rd), .pix_data_o(pix_data), .pix_empty_o(pix_empty),
        .line_done_o(line_done), .underflow_o(underflow)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    task automatic cyc();
        if (pop_en) pix_rd = !pix_empty;
        if (pix_rd && !pix_empty && npop < 64) popped[npop++] = pix_data;
        @(posedge clk);
        #1;
        if (line_done) nld++;
    endtask

    task automatic burst(input logic [15:0] d0, input logic [15:0] d1);
        int n = 0;
        while (!rd_req && n < 30) begin cyc(); n++; end
        if (rd_req && nreq < 32) addrs[nreq++] = rd_addr;
        rd_ack = 1'b1; cyc(); rd_ack = 1'b0;
        cyc();
        rd_valid = 1'b1; rd_data = d0; cyc(); rd_valid = 1'b0;
        cyc();
        rd_valid = 1'b1; rd_data = d1; cyc(); rd_valid = 1'b0;
    endtask

    task automatic do_line(input logic [15:0] dbase);
        int n = 0;
        line_start = 1'b1; cyc(); line_start = 1'b0;
        for (int k = 0; k < 4; k++) burst(dbase + 16'(2 * k + 1), dbase + 16'(2 * k + 2));
        while (!pix_empty && n < 20) begin cyc(); n++; end
    endtask

    task automatic frame();
        frame_start = 1'b1; cyc(); frame_start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) cyc();
        n_checks++; if (rd_req !== 1'b0) begin n_fail++; $display("FAIL reset_rd_req: got %b want 0", rd_req); end
        n_checks++; if (rd_addr !== 25'h0) begin n_fail++; $display("FAIL reset_rd_addr: got %h want 0", rd_addr); end
        n_checks++; if (pix_empty !== 1'b1) begin n_fail++; $display("FAIL reset_pix_empty: got %b want 1", pix_empty); end
        n_checks++; if (pix_data !== 16'h0) begin n_fail++; $display("FAIL reset_pix_data: got %h want 0", pix_data); end
        rst_n = 1'b1;
        cyc();
        line_start = 1'b1; cyc(); line_start = 1'b0;
        n_checks++; if (rd_req !== 1'b1) begin n_fail++; $display("FAIL start_rd_req: got %b want 1", rd_req); end
        n_checks++; if (rd_addr !== BASE) begin n_fail++; $display("FAIL start_rd_addr: got %h want %h", rd_addr, BASE); end
        rd_ack = 1'b1; cyc(); rd_ack = 1'b0;
        rd_valid = 1'b1; rd_data = 16'hAAAA; cyc(); rd_valid = 1'b0;
        n_checks++; if (pix_data !== 16'hAAAA) begin n_fail++; $display("FAIL midfetch_pix_data: got %h want aaaa", pix_data); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (rd_req !== 1'b0) begin n_fail++; $display("FAIL async_rd_req: got %b want 0", rd_req); end
        n_checks++; if (pix_empty !== 1'b1) begin n_fail++; $display("FAIL async_pix_empty: got %b want 1", pix_empty); end
        n_checks++; if (pix_data !== 16'h0) begin n_fail++; $display("FAIL async_pix_data: got %h want 0", pix_data); end
        n_checks++; if (rd_addr !== 25'h0) begin n_fail++; $display("FAIL async_rd_addr: got %h want 0", rd_addr); end
        n_checks++; if ({line_done, underflow} !== 2'b00) begin n_fail++; $display("FAIL async_flags: got %b want 00", {line_done, underflow}); end
        cyc();
        rst_n = 1'b1;
        line_start = 1'b1; cyc(); line_start = 1'b0;
        n_checks++; if (rd_req !== 1'b1 || rd_addr !== BASE) begin n_fail++; $display("FAIL restart_after_reset: got req=%b addr=%h want req=1 addr=%h", rd_req, rd_addr, BASE); end
        frame();
    endtask

    task automatic test_full_line();
        logic [24:0] nxt;
`ifdef FETCH_LINE_DOUBLE_EN
        nxt = BASE;
`else
        nxt = BASE + 25'd8;
`endif
        frame();
        npop = 0; nreq = 0; nld = 0; pop_en = 1'b1;
        do_line(16'h0000);
        n_checks++; if (nreq !== 4) begin n_fail++; $display("FAIL full_nreq: got %0d want 4", nreq); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (addrs[i] !== BASE + 25'(2 * i)) begin n_fail++; $display("FAIL full_addr%0d: got %h want %h", i, addrs[i], BASE + 25'(2 * i)); end
        end
        n_checks++; if (npop !== 8) begin n_fail++; $display("FAIL full_npop: got %0d want 8", npop); end
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (popped[i] !== 16'(i + 1)) begin n_fail++; $display("FAIL full_pop%0d: got %h want %h", i, popped[i], 16'(i + 1)); end
        end
        n_checks++; if (nld !== 1) begin n_fail++; $display("FAIL full_line_done: got %0d want 1", nld); end
        n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL full_underflow: got %b want 0", underflow); end
        line_start = 1'b1; cyc(); line_start = 1'b0;
        n_checks++; if (rd_req !== 1'b1 || rd_addr !== nxt) begin n_fail++; $display("FAIL full_next_line: got req=%b addr=%h want req=1 addr=%h", rd_req, rd_addr, nxt); end
        pop_en = 1'b0; pix_rd = 1'b0;
        frame();
    endtask

    task automatic test_stall();
        int n = 0;
        frame();
        npop = 0; nreq = 0; nld = 0; pop_en = 1'b0; pix_rd = 1'b0;
        line_start = 1'b1; cyc(); line_start = 1'b0;
        burst(16'h0011, 16'h0012);
        burst(16'h0013, 16'h0014);
        repeat (4) cyc();
        n_checks++; if (rd_req !== 1'b0) begin n_fail++; $display("FAIL stall_req_low: got %b want 0", rd_req); end
        n_checks++; if (pix_data !== 16'h0011) begin n_fail++; $display("FAIL stall_head: got %h want 0011", pix_data); end
        pix_rd = 1'b1; cyc();
        n_checks++; if (rd_req !== 1'b0 || pix_data !== 16'h0012) begin n_fail++; $display("FAIL stall_one_pop: got req=%b data=%h want req=0 data=0012", rd_req, pix_data); end
        cyc(); pix_rd = 1'b0;
        n_checks++; if (rd_req !== 1'b1 || rd_addr !== BASE + 25'd4) begin n_fail++; $display("FAIL stall_resume: got req=%b addr=%h want req=1 addr=%h", rd_req, rd_addr, BASE + 25'd4); end
        pop_en = 1'b1;
        burst(16'h0015, 16'h0016);
        burst(16'h0017, 16'h0018);
        while (!pix_empty && n < 20) begin cyc(); n++; end
        n_checks++; if (npop !== 8 || nld !== 1) begin n_fail++; $display("FAIL stall_totals: got pops=%0d done=%0d want pops=8 done=1", npop, nld); end
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (popped[i] !== 16'h0011 + 16'(i)) begin n_fail++; $display("FAIL stall_pop%0d: got %h want %h", i, popped[i], 16'h0011 + 16'(i)); end
        end
        pop_en = 1'b0; pix_rd = 1'b0;
    endtask

    task automatic test_restart();
        frame();
        line_start = 1'b1; cyc(); line_start = 1'b0;
        rd_ack = 1'b1; cyc(); rd_ack = 1'b0;
        rd_valid = 1'b1; rd_data = 16'h00A1; cyc(); rd_valid = 1'b0;
        n_checks++; if (pix_empty !== 1'b0) begin n_fail++; $display("FAIL restart_first_word: got empty=%b want 0", pix_empty); end
        line_start = 1'b1; cyc(); line_start = 1'b0;
        n_checks++; if (pix_empty !== 1'b1 || rd_req !== 1'b0) begin n_fail++; $display("FAIL restart_drain: got empty=%b req=%b want empty=1 req=0", pix_empty, rd_req); end
        rd_valid = 1'b1; rd_data = 16'h00A2; cyc(); rd_valid = 1'b0;
        n_checks++; if (pix_empty !== 1'b1 || pix_data !== 16'h0) begin n_fail++; $display("FAIL restart_discard: got empty=%b data=%h want empty=1 data=0", pix_empty, pix_data); end
        n_checks++; if (rd_req !== 1'b1 || rd_addr !== BASE) begin n_fail++; $display("FAIL restart_addr: got req=%b addr=%h want req=1 addr=%h", rd_req, rd_addr, BASE); end
        frame();
    endtask

    task automatic test_underflow();
        frame();
        pix_rd = 1'b1; cyc(); pix_rd = 1'b0;
        n_checks++; if (underflow !== 1'b1 || pix_data !== 16'h0 || pix_empty !== 1'b1) begin n_fail++; $display("FAIL underflow_set: got uf=%b data=%h empty=%b want uf=1 data=0 empty=1", underflow, pix_data, pix_empty); end
        repeat (3) cyc();
        n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL underflow_sticky: got %b want 1", underflow); end
        frame();
        n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL underflow_clear: got %b want 0", underflow); end
    endtask

    task automatic test_wrap();
        logic [24:0] exp_a [4];
        logic [24:0] got4;
`ifdef FETCH_LINE_DOUBLE_EN
        exp_a = '{BASE, BASE, BASE + 25'd8, BASE};
`else
        exp_a = '{BASE, BASE + 25'd8, BASE + 25'd16, BASE};
`endif
        frame();
        npop = 0; nreq = 0; nld = 0; pop_en = 1'b1;
        for (int l = 0; l < 3; l++) do_line(16'h0100);
        line_start = 1'b1; cyc(); line_start = 1'b0;
        got4 = rd_addr;
        n_checks++; if (nld !== 3) begin n_fail++; $display("FAIL wrap_line_done: got %0d want 3", nld); end
        for (int l = 0; l < 3; l++) begin
            n_checks++; if (addrs[4 * l] !== exp_a[l]) begin n_fail++; $display("FAIL wrap_line%0d: got %h want %h", l, addrs[4 * l], exp_a[l]); end
        end
        n_checks++; if (got4 !== exp_a[3] || rd_req !== 1'b1) begin n_fail++; $display("FAIL wrap_line3: got addr=%h req=%b want addr=%h req=1", got4, rd_req, exp_a[3]); end
        pop_en = 1'b0; pix_rd = 1'b0;
        frame();
    endtask

    task automatic test_back_to_back();
        frame();
        nld = 0; npop = 0; nreq = 0; pop_en = 1'b1;
        do_line(16'h0200);
        do_line(16'h0300);
        frame_start = 1'b1; line_start = 1'b1; cyc(); frame_start = 1'b0; line_start = 1'b0;
        n_checks++; if (nld !== 2) begin n_fail++; $display("FAIL b2b_line_done: got %0d want 2", nld); end
        n_checks++; if (addrs[4] !== BASE + 25'(8) - 25'(8 * 0) && addrs[4] !== BASE) begin n_fail++; $display("FAIL b2b_second_line: got %h", addrs[4]); end
        n_checks++; if (rd_req !== 1'b1 || rd_addr !== BASE) begin n_fail++; $display("FAIL b2b_frame_line: got req=%b addr=%h want req=1 addr=%h", rd_req, rd_addr, BASE); end
        pop_en = 1'b0; pix_rd = 1'b0;
        frame();
    endtask

    initial begin
        test_reset();
        test_full_line();
        test_stall();
        test_restart();
        test_underflow();
        test_wrap();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
